// File: rtl/security_pkg.sv
// ============================================================================
// Module      : security_pkg
// Description : Shared types and constants for the keypad passcode checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package security_pkg;

    localparam int DIGIT_W = 2;
    localparam int NUM_BTN = 4;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        ENTRY    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/edge_pulse.sv
// ============================================================================
// Module      : edge_pulse
// Description : Registers a level and flags its rising edges (in & ~q).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_pulse #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_level,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] level_q;

    always_comb level_d = i_level;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= RST_VAL;
        end else begin
            level_q <= level_d;
        end
    end

    assign o_rise = i_level & ~level_q;

endmodule

`default_nettype wire

// File: rtl/passcode_fsm.sv
// ============================================================================
// Module      : passcode_fsm
// Description : Keypad passcode checker with fail counting and timed lockout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module passcode_fsm
    import security_pkg::*;
#(
    parameter int                             CODE_LEN      = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]    CODE          = 8'b01_11_00_10,
    parameter int                             MAX_FAILS     = 3,
    parameter int unsigned                    ENTRY_TIMEOUT = 250_000_000,
    parameter int unsigned                    LOCK_CYCLES   = 500_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               lock_req,
    output logic               unlocked,
    output logic               alarm,
    output logic               entry_error,
    output logic [2:0]         digit_count,
    output logic [2:0]         fail_count
);

    localparam int unsigned TMR_MAX = (ENTRY_TIMEOUT > LOCK_CYCLES) ? ENTRY_TIMEOUT : LOCK_CYCLES;
    localparam int          TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] ENTRY_LAST = TMR_W'(ENTRY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST  = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_SAT    = TMR_W'(TMR_MAX);
    localparam logic [2:0]       CODE_LEN_C  = 3'(CODE_LEN);
    localparam logic [2:0]       MAX_FAILS_C = 3'(MAX_FAILS);

    logic [NUM_BTN-1:0] press;
    logic               lock_rise;

    state_t             state_d, state_q;
    logic [2:0]         digit_count_d, digit_count_q;
    logic [2:0]         fail_count_d, fail_count_q;
    logic               mismatch_d, mismatch_q;
    logic               entry_error_d, entry_error_q;
    logic [TMR_W-1:0]   tmr_d, tmr_q;

    logic               press_any;
    logic               digit_bad;
    logic [DIGIT_W-1:0] digit;
    logic [DIGIT_W-1:0] exp_digit;
    logic [2:0]         count_next;
    logic [2:0]         fail_next;
    logic [TMR_W-1:0]   tmr_inc;

    // Reset value of all ones: a button held through reset never counts as a press.
    edge_pulse #(
        .WIDTH   (NUM_BTN),
        .RST_VAL ({NUM_BTN{1'b1}})
    ) u_btn_edge (
        .clock   (clock),
        .reset   (reset),
        .i_level (btn),
        .o_rise  (press)
    );

    edge_pulse #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_lock_edge (
        .clock   (clock),
        .reset   (reset),
        .i_level (lock_req),
        .o_rise  (lock_rise)
    );

    always_comb begin
        press_any = |press;
        digit     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (press[i]) digit = DIGIT_W'(i);
        end
        exp_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (digit_count_q == 3'(i)) exp_digit = CODE[i*DIGIT_W +: DIGIT_W];
        end
        // Simultaneous presses still consume a digit but can never match.
        digit_bad  = !$onehot(press) || (digit != exp_digit);
        count_next = digit_count_q + 3'd1;
        fail_next  = fail_count_q + 3'd1;
        tmr_inc    = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + TMR_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        digit_count_d = digit_count_q;
        fail_count_d  = fail_count_q;
        mismatch_d    = mismatch_q;
        entry_error_d = 1'b0;
        tmr_d         = tmr_q;

        case (state_q)
            LOCKED: begin
                tmr_d = '0;
                if (press_any) begin
                    digit_count_d = 3'd1;
                    mismatch_d    = digit_bad;
                    state_d       = ENTRY;
                end
            end
            ENTRY: begin
                if (press_any) begin
                    tmr_d = '0;
                    if (count_next == CODE_LEN_C) begin
                        digit_count_d = '0;
                        mismatch_d    = 1'b0;
                        if (!(mismatch_q || digit_bad)) begin
                            fail_count_d = '0;
                            state_d      = UNLOCKED;
                        end else begin
                            fail_count_d  = fail_next;
                            entry_error_d = 1'b1;
                            state_d       = (fail_next == MAX_FAILS_C) ? LOCKOUT : LOCKED;
                        end
                    end else begin
                        digit_count_d = count_next;
                        mismatch_d    = mismatch_q | digit_bad;
                    end
                end else if (tmr_q == ENTRY_LAST) begin
                    digit_count_d = '0;
                    mismatch_d    = 1'b0;
                    tmr_d         = '0;
                    state_d       = LOCKED;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            UNLOCKED: begin
                tmr_d = '0;
                if (lock_rise) state_d = LOCKED;
            end
            LOCKOUT: begin
                if (tmr_q == LOCK_LAST) begin
                    fail_count_d = '0;
                    tmr_d        = '0;
                    state_d      = LOCKED;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= LOCKED;
            digit_count_q <= '0;
            fail_count_q  <= '0;
            mismatch_q    <= 1'b0;
            entry_error_q <= 1'b0;
            tmr_q         <= '0;
        end else begin
            state_q       <= state_d;
            digit_count_q <= digit_count_d;
            fail_count_q  <= fail_count_d;
            mismatch_q    <= mismatch_d;
            entry_error_q <= entry_error_d;
            tmr_q         <= tmr_d;
        end
    end

    assign unlocked    = (state_q == UNLOCKED);
    assign alarm       = (state_q == LOCKOUT);
    assign entry_error = entry_error_q;
    assign digit_count = digit_count_q;
    assign fail_count  = fail_count_q;

endmodule

`default_nettype wire

// File: tb/tb_passcode_fsm.sv
// ============================================================================
// Module      : tb_passcode_fsm
// Description : Directed, table-driven self-checking bench for passcode_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_passcode_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       lock_req;
    logic       unlocked;
    logic       alarm;
    logic       entry_error;
    logic [2:0] digit_count;
    logic [2:0] fail_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] b;
        logic       l;
        logic       unl;
        logic       alm;
        logic       err;
        logic [2:0] dc;
        logic [2:0] fc;
    } vec_t;

    vec_t tbl [13];

    passcode_fsm #(
        .CODE_LEN      (4),
        .CODE          (8'b01_11_00_10),
        .MAX_FAILS     (3),
        .ENTRY_TIMEOUT (10),
        .LOCK_CYCLES   (20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn         (btn),
        .lock_req    (lock_req),
        .unlocked    (unlocked),
        .alarm       (alarm),
        .entry_error (entry_error),
        .digit_count (digit_count),
        .fail_count  (fail_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int unl, input int alm,
                              input int err, input int dc, input int fc);
        check({tag, ".unlocked"},    int'(unlocked),    unl);
        check({tag, ".alarm"},       int'(alarm),       alm);
        check({tag, ".entry_error"}, int'(entry_error), err);
        check({tag, ".digit_count"}, int'(digit_count), dc);
        check({tag, ".fail_count"},  int'(fail_count),  fc);
    endtask

    // Drive inputs, take the active edge, and leave time at edge+1.
    task automatic apply_step(input logic [3:0] b, input logic l);
        @(negedge clock);
        btn      = b;
        lock_req = l;
        @(posedge clock);
        #1;
    endtask

    // Hold for a second edge, then release for one cycle (presses 3 apart).
    task automatic finish_step();
        @(posedge clock);
        @(negedge clock);
        btn      = 4'b0000;
        lock_req = 1'b0;
        @(posedge clock);
    endtask

    task automatic press_step(input logic [3:0] b);
        apply_step(b, 1'b0);
        finish_step();
    endtask

    initial begin
        int n;
        int bad;
        int err_seen;

        // Code 2,0,3,1: one-hot buttons 0100,0001,1000,0010.
        tbl[0]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0};
        tbl[1]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0};
        tbl[2]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0};
        tbl[3]  = '{4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0};
        tbl[4]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0};
        tbl[5]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0};
        tbl[6]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0};
        tbl[7]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0};
        tbl[8]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd1};
        tbl[9]  = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd1};
        tbl[10] = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1};
        tbl[11] = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd1};
        tbl[12] = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd2};

        // Button 2 held through reset release must not register.
        reset    = 1'b1;
        btn      = 4'b0100;
        lock_req = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_outs("reset_hold", 0, 0, 0, 0, 0);
        @(negedge clock);
        btn = 4'b0000;
        @(posedge clock);
        #1;
        check("reset_release.digit_count", int'(digit_count), 0);

        for (int i = 0; i < 13; i++) begin
            apply_step(tbl[i].b, tbl[i].l);
            check_outs($sformatf("vec%0d", i), int'(tbl[i].unl), int'(tbl[i].alm),
                       int'(tbl[i].err), int'(tbl[i].dc), int'(tbl[i].fc));
            finish_step();
        end

        // Third wrong code enters lockout.
        press_step(4'b0100);
        press_step(4'b0001);
        press_step(4'b1000);
        apply_step(4'b0100, 1'b0);
        check_outs("lockout_enter", 0, 1, 1, 0, 3);
        n   = 1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            btn = (i % 3 == 0) ? 4'b0001 : 4'b0000;
            @(posedge clock);
            #1;
            if (i == 0) check("lockout_err_pulse_width", int'(entry_error), 0);
            if (digit_count != 3'd0) bad = 1;
            if (alarm) n++;
            else break;
        end
        check("lockout_alarm_cycles", n, 20);
        check("lockout_presses_ignored", bad, 0);
        check("lockout_exit.fail_count", int'(fail_count), 0);
        @(negedge clock);
        btn = 4'b0000;
        repeat (2) @(posedge clock);
        #1;
        check("after_lockout.digit_count", int'(digit_count), 0);

        press_step(4'b0100);
        press_step(4'b0001);
        press_step(4'b1000);
        apply_step(4'b0010, 1'b0);
        check_outs("unlock_after_lockout", 1, 0, 0, 0, 0);
        finish_step();
        apply_step(4'b0000, 1'b1);
        check("relock1.unlocked", int'(unlocked), 0);
        finish_step();

        // Entry timeout: last press at edge P, back to LOCKED at P+10.
        press_step(4'b0100);
        apply_step(4'b0001, 1'b0);
        check("timeout_start.digit_count", int'(digit_count), 2);
        err_seen = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 2) btn = 4'b0000;
            @(posedge clock);
            #1;
            if (entry_error) err_seen = 1;
            if (k == 9) check("timeout_p9.digit_count", int'(digit_count), 2);
        end
        check("timeout_p10.digit_count", int'(digit_count), 0);
        check("timeout.no_entry_error", err_seen, 0);
        check("timeout.fail_count", int'(fail_count), 0);

        press_step(4'b0100);
        press_step(4'b0001);
        press_step(4'b1000);
        apply_step(4'b0010, 1'b0);
        check("unlock_after_timeout.unlocked", int'(unlocked), 1);
        finish_step();
        apply_step(4'b0000, 1'b1);
        check("relock2.unlocked", int'(unlocked), 0);
        finish_step();

        // A press landing exactly on the expiry edge wins.
        press_step(4'b0100);
        apply_step(4'b0001, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 2)  btn = 4'b0000;
            if (k == 10) btn = 4'b1000;
            @(posedge clock);
            #1;
        end
        check("tiebreak.digit_count", int'(digit_count), 3);
        finish_step();
        apply_step(4'b0010, 1'b0);
        check("tiebreak_unlock.unlocked", int'(unlocked), 1);
        finish_step();
        apply_step(4'b0000, 1'b1);
        check("relock3.unlocked", int'(unlocked), 0);
        finish_step();

        // Asynchronous reset in the middle of a lockout.
        for (int r = 0; r < 3; r++) begin
            press_step(4'b0100);
            press_step(4'b0001);
            press_step(4'b1000);
            press_step(4'b0100);
        end
        repeat (3) @(posedge clock);
        #1;
        check("pre_reset.alarm", int'(alarm), 1);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset.alarm", int'(alarm), 0);
        check("async_reset.fail_count", int'(fail_count), 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_outs("post_reset", 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
